// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full adder, one bit per clock, LSB first.
// Optional signed-overflow flag output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_x ^ i_y ^ i_ci;
    assign o_co = (i_x & i_y) | (i_ci & (i_x ^ i_y));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a_sh, r_b_sh, r_s_sh, r_sum;
    logic             r_carry, r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_accept, w_last;
    logic             w_s, w_co;
    logic [WIDTH-1:0] w_s_next;

    full_adder u_fa (
        .i_x  (r_a_sh[0]),
        .i_y  (r_b_sh[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_s_next = {w_s, r_s_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
        case (r_state)
            S_IDLE: if (start) begin
                w_accept = 1'b1;
                w_next   = S_RUN;
            end
            S_RUN:  if (w_last) w_next = S_DONE;
            S_DONE: begin
                // A start in the DONE cycle chains straight into the next operation.
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_s_sh  <= '0;
            r_carry <= c_in;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_s_sh  <= w_s_next;
            r_carry <= w_co;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_s_next;
                r_cout <= w_co;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;
    // On the MSB edge r_carry is the carry into the MSB and w_co the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_carry ^ w_co;
    end
    assign ovf = r_ovf;
`endif

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign c_out = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); expected results queue on accept, pop on done.

module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk, rst_n, start, c_in;
    logic [WIDTH-1:0] a, b, sum;
    logic             busy, done, c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] last_sum = '0;
    logic             last_cout = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
        logic [WIDTH:0] full;
        exp_t e;
        full   = {1'b0, xa} + {1'b0, xb} + {{WIDTH{1'b0}}, xc};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (xa[WIDTH-1] == xb[WIDTH-1]) && (full[WIDTH-1] != xa[WIDTH-1]);
        sb.push_back(e);
    endtask

    // Drive one accepted request; returns #1 after the accepting edge.
    task automatic go(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
        a = xa; b = xb; c_in = xc; start = 1'b1;
        push(xa, xb, xc);
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom);
    endtask

    // Waits for done, sampling #1 after each edge; lat = edges waited, bc = busy samples seen.
    task automatic wait_done(input int max, output int lat, output int bc);
        lat = -1; bc = 0;
        for (int k = 1; k <= max; k++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", sum, e.sum);
                    chk("c_out", c_out, e.cout);
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", ovf, e.ovf);
`endif
                    last_sum  = e.sum;
                    last_cout = e.cout;
                end
            end else if (busy) begin
                chk("hold_sum", sum, last_sum);
                chk("hold_cout", c_out, last_cout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, bc, nd, l2, l3;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        // Basic op: latency and busy length
        go(8'h5A, 8'h3C, 1'b0);
        chk("busy_after_accept", busy, 1);
        wait_done(20, lat, bc);
        chk("latency", lat, WIDTH);
        chk("busy_cycles", bc, WIDTH - 1);
        chk("done_busy_low", busy, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        go(8'hFF, 8'h01, 1'b0);
        wait_done(20, lat, bc);

        // Start held high: back-to-back accepts, done spacing WIDTH+1
        a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
        push(8'hFF, 8'hFF, 1'b1); push(8'hFF, 8'hFF, 1'b1); push(8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #1;
        wait_done(20, lat, bc);
        chk("b2b_lat1", lat, WIDTH);
        wait_done(20, l2, bc);
        wait_done(20, l3, bc);
        start = 1'b0;
        chk("b2b_space2", l2, WIDTH + 1);
        chk("b2b_space3", l3, WIDTH + 1);
        count_done(12, nd);
        chk("b2b_no_extra", nd, 0);

        // Start during RUN is ignored
        go(8'h10, 8'h20, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20, lat, bc);
        chk("ignore_lat", lat, WIDTH - 3);
        count_done(12, nd);
        chk("ignore_one_done", nd, 0);

        // Reset mid-RUN aborts
        go(8'h0F, 8'h01, 1'b0);
        @(posedge clk); @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", c_out, 0);
        sb.delete();
        last_sum = '0; last_cout = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        count_done(14, nd);
        chk("abort_no_done", nd, 0);
        go(8'h0F, 8'h01, 1'b0);
        wait_done(20, lat, bc);
        chk("post_rst_lat", lat, WIDTH);

        // Boundaries and signed-overflow patterns (ovf checked when enabled)
        go(8'h00, 8'h00, 1'b0); wait_done(20, lat, bc);
        go(8'h00, 8'h00, 1'b1); wait_done(20, lat, bc);
        go(8'h7F, 8'h01, 1'b0); wait_done(20, lat, bc);
        go(8'h80, 8'h80, 1'b0); wait_done(20, lat, bc);
        go(8'hFF, 8'h01, 1'b0); wait_done(20, lat, bc);
        go(8'h7F, 8'h00, 1'b1); wait_done(20, lat, bc);

        for (int i = 0; i < 8; i++) begin
            go(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_done(20, lat, bc);
        end

        @(posedge clk); @(posedge clk); #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial addition controller. It time-shares one full_adder instance across a WIDTH-bit operation, processing one bit per clock, LSB first. Operands, carry-in and results are buffered internally. A start/busy/done handshake lets a host sequence multi-bit additions through minimal adder hardware.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when the controller is ready (IDLE or DONE).
a  input  WIDTH  operand A; captured on the accepting edge.
b  input  WIDTH  operand B; captured on the accepting edge.
c_in  input  1  carry-in; captured on the accepting edge.
busy  output  1  high while in RUN.
done  output  1  single-cycle pulse; result valid.
sum  output  WIDTH  result register; holds last completed result.
c_out  output  1  final carry of last completed operation.

Behaviour:
- Single clock domain: clk. Reset is rst_n, asynchronous and active-low. On assertion, all state clears immediately, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, c_out=0. Internal shift registers, carry register and bit counter are also 0.
- FSM states:
  - IDLE: start=1 -> RUN, and on that edge capture a, b and c_in.
  - RUN: one bit per edge. Exits to DONE after the WIDTH-th bit.
  - DONE: lasts exactly 1 cycle. start=1 -> RUN with capture (back-to-back); otherwise -> IDLE.
- Datapath per RUN edge:
  - The full_adder inputs are x=a_sh[0], y=b_sh[0], c_in=carry_q.
  - a_sh and b_sh shift right by one.
  - Adder s shifts into s_sh[WIDTH-1] (right-shift).
  - carry_q <= adder c_out.
  - cnt increments; cnt width is $clog2(WIDTH)+1.
- Completion: on the edge processing bit WIDTH-1:
  - sum <= final s_sh contents and c_out <= final carry, loaded together.
  - state -> DONE.
- Latency: if start is accepted at edge E0, bits are processed at edges E1..E_WIDTH. done=1 in the cycle after E_WIDTH (WIDTH cycles after acceptance). Throughput is one result per WIDTH+1 cycles back-to-back.
- busy is 1 from the cycle after acceptance until the completion edge; it is 0 during DONE.
- done is high only during DONE, never for more than 1 cycle per operation.
- sum and c_out change only at completion. They are stable during RUN and hold the previous result.
- start in RUN is ignored. It is not queued, and the operands in flight are unaffected.
- Operand changes after acceptance have no effect.
- Reset mid-RUN aborts the operation: outputs return to reset values and no done pulse follows.
- Arithmetic is unsigned modulo 2^WIDTH. c_out is bit WIDTH of a+b+c_in.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (output, 1 bit), which flags two's-complement signed overflow.
  - ovf = carry into the MSB XOR carry out of the MSB, captured during the MSB-bit edge.
  - ovf is loaded together with sum and c_out, holds until the next completion, and resets to 0.
- Undefined: no ovf port and no associated register; all other behaviour is identical.

Test Plan:
1. WIDTH=8; after reset, check outputs before any start -> busy=0, done=0, sum=0x00, c_out=0.
2. a=0x5A, b=0x3C, c_in=0, start 1 cycle -> busy for 8 cycles, done pulse 8 cycles after acceptance, sum=0x96, c_out=0. Then a=0xFF, b=0x01 -> sum=0x00, c_out=1.
3. a=0xFF, b=0xFF, c_in=1; start held high continuously -> results sum=0xFF, c_out=1. A new operation is accepted in the DONE cycle, so done pulses are spaced exactly 9 cycles apart.
4. Start a=0x10, b=0x20; at cycle 3 of RUN drive start=1, a=0xAA, b=0x55 -> ignored; result sum=0x30, c_out=0, exactly one done pulse.
5. Start a=0x0F, b=0x01; assert rst_n=0 at cycle 4 of RUN -> busy, done, sum, c_out all 0 immediately; no done after release. A fresh start then yields the correct result.
6. With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1, c_out=0. a=0x80, b=0x80 -> sum=0x00, ovf=1, c_out=1. a=0xFF, b=0x01 -> ovf=0.
